ram_dp_clr: RTL and testbench
=============================

// Module: ram_dp_clr
// PURPOSE
//  True dual-port synchronous RAM for ODE accelerator state/coefficient storage.
//  Both ports read and write, with a registered 1-cycle read.
//  A built-in clear sequencer zeroes every word after reset or on request, one word per cycle.
//  Requests arriving during a clear are dropped.
// PARAMETERS
//  ADDRESS_SIZE  4   address width; DEPTH = 2**ADDRESS_SIZE words
//  WORD_SIZE     32  data word width in bits
// PORTS
//  clk      in   1             single clock; all logic on rising edge
//  rst_n    in   1             synchronous reset, active-low
//  clr      in   1             pulse: start a memory clear (honoured only when idle)
//  busy     out  1             1 while reset is held or a clear is running
//  en_a     in   1             port A request strobe
//  we_a     in   1             port A write (1) / read (0); qualified by en_a
//  addr_a   in   ADDRESS_SIZE  port A address
//  wdata_a  in   WORD_SIZE     port A write data
//  rdata_a  out  WORD_SIZE     port A read data (registered)
//  rvalid_a out  1             port A read data valid, 1-cycle pulse
//  en_b, we_b, addr_b, wdata_b, rdata_b, rvalid_b: port B, identical to port A
// BEHAVIOUR
//  Reset: rst_n sampled low -> state CLEAR, clr_cnt=0, busy=1, rdata_a/b=0, rvalid_a/b=0.
//   While rst_n stays low, the counter holds at 0 and no memory word is written.
//  FSM: IDLE, CLEAR.
//   CLEAR: each cycle mem[clr_cnt]<=0, clr_cnt++; at clr_cnt==DEPTH-1 write last word, go IDLE.
//   First cycle after rst_n rises -> word 0 cleared; busy falls after exactly DEPTH cycles (16 default).
//   IDLE: clr==1 -> CLEAR with clr_cnt=0, busy=1 from next cycle. clr is ignored while in CLEAR.
//   rst_n low mid-clear -> restart: counter back to 0, sequence begins again after release.
//  busy is a registered output: 1 in CLEAR and under reset, 0 in IDLE.
//  Access, only when state==IDLE:
//   en&we  -> mem[addr]<=wdata at the edge; rvalid=0 next cycle.
//   en&!we -> rdata<=mem[addr] at the edge; rvalid=1 for one cycle. Latency 1.
//   en=0   -> rvalid=0.
//  rdata holds its last value whenever rvalid=0.
//  Requests while busy are dropped: no write, rvalid stays 0, rdata unchanged.
//  Collisions, same address in the same cycle:
//   A write + B write   -> port A data is stored; port B write is lost.
//   write + other-port read -> read-first: read returns the old word (see CONFIGURATION).
//   A read + B read     -> both return the same word.
//  A write takes effect for reads issued in the following cycle on either port.
//  Addresses are ADDRESS_SIZE bits wide, so no out-of-range case exists.
//  The clear counter is ADDRESS_SIZE+1 bits wide to avoid wrap aliasing.
// CONFIGURATION
//  RAM_BYPASS_EN defined: write-first forwarding.
//   A read colliding with a same-cycle other-port write returns that write's wdata.
//   In a double-write collision, a read on either port returns port A's data.
//  RAM_BYPASS_EN undefined: read-first; the colliding read returns the pre-write mem contents.
//  No other behaviour differs.
// TESTING
//  1 Reset clear: preload mem[3]=32'hDEADBEEF via hierarchy; rst_n low 2 cycles, then high.
//    -> busy=1 for exactly 16 cycles, then 0; read every address returns 0.
//  2 Write/read: A write addr 3 = 32'hAAAAAAAA; next cycle B read addr 3.
//    -> one cycle later rdata_b=32'hAAAAAAAA, rvalid_b=1 for one cycle; rdata_a unchanged.
//  3 Dual write collision: A writes 32'h55555555 and B writes 32'h12345678, both to addr 1.
//    -> a later read of addr 1 returns 32'h55555555.
//  4 Read/write collision: mem[5]=0; A writes 32'hCAFEF00D to addr 5 while B reads addr 5.
//    -> rdata_b=0 without RAM_BYPASS_EN; rdata_b=32'hCAFEF00D with it.
//  5 clr mid-traffic: in IDLE pulse clr, then issue an A write to addr 2 on the next cycle.
//    -> busy=1 for 16 cycles; the write is dropped; mem[2]=0; rvalid stays 0 throughout.
//  6 Reset mid-clear: drop rst_n at clear cycle 7, hold 1 cycle, release.
//    -> busy stays 1 for 16 more cycles; all words read 0 afterwards.

Source files
------------

// File: rtl/ram_dp_clr.sv
// True dual-port RAM with a registered 1-cycle read and a built-in clear sequencer.
// RAM_BYPASS_EN selects write-first forwarding on same-address read/write collisions.
module ram_dp_clr #(
    parameter int ADDRESS_SIZE = 4,
    parameter int WORD_SIZE    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    output logic                    busy,
    input  logic                    en_a,
    input  logic                    we_a,
    input  logic [ADDRESS_SIZE-1:0] addr_a,
    input  logic [WORD_SIZE-1:0]    wdata_a,
    output logic [WORD_SIZE-1:0]    rdata_a,
    output logic                    rvalid_a,
    input  logic                    en_b,
    input  logic                    we_b,
    input  logic [ADDRESS_SIZE-1:0] addr_b,
    input  logic [WORD_SIZE-1:0]    wdata_b,
    output logic [WORD_SIZE-1:0]    rdata_b,
    output logic                    rvalid_b
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] LAST_CNT = (ADDRESS_SIZE + 1)'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDRESS_SIZE:0]   r_clr_cnt;
    logic                    r_busy;
    logic [WORD_SIZE-1:0]    r_mem [DEPTH];
    logic [WORD_SIZE-1:0]    r_rdata_a;
    logic [WORD_SIZE-1:0]    r_rdata_b;
    logic                    r_rvalid_a;
    logic                    r_rvalid_b;

    logic                    w_idle;
    logic                    w_wr_a;
    logic                    w_wr_b;
    logic                    w_rd_a;
    logic                    w_rd_b;
    logic [WORD_SIZE-1:0]    w_rd_word_a;
    logic [WORD_SIZE-1:0]    w_rd_word_b;

    assign w_idle = (r_state == ST_IDLE);
    assign w_wr_a = w_idle & en_a & we_a;
    assign w_wr_b = w_idle & en_b & we_b;
    assign w_rd_a = w_idle & en_a & ~we_a;
    assign w_rd_b = w_idle & en_b & ~we_b;

`ifdef RAM_BYPASS_EN
    // Port A write has priority, so port B forwards A's data first.
    assign w_rd_word_a = (w_wr_b && (addr_b == addr_a)) ? wdata_b : r_mem[addr_a];
    assign w_rd_word_b = (w_wr_a && (addr_a == addr_b)) ? wdata_a : r_mem[addr_b];
`else
    assign w_rd_word_a = r_mem[addr_a];
    assign w_rd_word_b = r_mem[addr_b];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes reads return the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == LAST_CNT) begin
                        r_state   <= ST_IDLE;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the array has no reset term; the clear sequencer zeroes it word by
    // word, which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt[ADDRESS_SIZE-1:0]] <= '0;
            end else begin
                // A is written last so it wins a same-address double write.
                if (w_wr_b) r_mem[addr_b] <= wdata_b;
                if (w_wr_a) r_mem[addr_a] <= wdata_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata_a  <= '0;
            r_rvalid_a <= 1'b0;
            r_rdata_b  <= '0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_a <= w_rd_a;
            r_rvalid_b <= w_rd_b;
            if (w_rd_a) r_rdata_a <= w_rd_word_a;
            if (w_rd_b) r_rdata_b <= w_rd_word_b;
        end
    end

    assign busy     = r_busy;
    assign rdata_a  = r_rdata_a;
    assign rvalid_a = r_rvalid_a;
    assign rdata_b  = r_rdata_b;
    assign rvalid_b = r_rvalid_b;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: directed vector table plus clear/reset sequences.
module tb_ram_dp_clr;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int BUSY_BOUND = 100;

`ifdef RAM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          busy;
    logic          en_a, we_a, en_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b;

    int checks = 0;
    int failures = 0;

    ram_dp_clr #(.ADDRESS_SIZE(AW), .WORD_SIZE(DW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b), .rvalid_b(rvalid_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en_a, we_a;
        logic [AW-1:0] addr_a;
        logic [DW-1:0] wdata_a;
        logic          en_b, we_b;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] wdata_b;
        logic          exp_rvalid_a;
        logic [DW-1:0] exp_rdata_a;
        logic          exp_rvalid_b;
        logic [DW-1:0] exp_rdata_b;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        en_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        en_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        clr = 1'b0;
    endtask

    // Counts edges until busy is seen low; rvalid must stay low throughout.
    task automatic wait_idle(input string name);
        int n = 0;
        int rv_seen = 0;
        while (busy === 1'b1 && n < BUSY_BOUND) begin
            step();
            n++;
            idle_inputs();
            if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) rv_seen++;
        end
        check({name, "_busy_cycles"}, DW'(n), DW'(DEPTH));
        check({name, "_rvalid_quiet"}, DW'(rv_seen), 0);
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1'b1; we_a = 1'b0; addr_a = AW'(i);
            en_b = 1'b1; we_b = 1'b0; addr_b = AW'(DEPTH - 1 - i);
            step();
            idle_inputs();
            check($sformatf("%s_rd_a%0d", name, i), rdata_a, '0);
            check($sformatf("%s_rv_a%0d", name, i), DW'(rvalid_a), 1);
            check($sformatf("%s_rd_b%0d", name, DEPTH - 1 - i), rdata_b, '0);
        end
        step();
    endtask

    function automatic vec_t mk(
        input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
        input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
        input logic va, input logic [DW-1:0] ra, input logic vb, input logic [DW-1:0] rb);
        vec_t v;
        v.en_a = ea; v.we_a = wa; v.addr_a = aa; v.wdata_a = da;
        v.en_b = eb; v.we_b = wb; v.addr_b = ab; v.wdata_b = db;
        v.exp_rvalid_a = va; v.exp_rdata_a = ra;
        v.exp_rvalid_b = vb; v.exp_rdata_b = rb;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] coll_b = BYPASS ? 32'hCAFEF00D : 32'h0;
        logic [DW-1:0] coll_a = BYPASS ? 32'h00000099 : 32'h0;

        // Memory starts cleared; rdata starts at 0 after the clear.
        vecs[0]  = mk(1,1,3,32'hAAAAAAAA, 0,0,0,0,           0,0,            0,0);
        vecs[1]  = mk(0,0,0,0,            1,0,3,0,           0,0,            1,32'hAAAAAAAA);
        vecs[2]  = mk(0,0,0,0,            0,0,0,0,           0,0,            0,32'hAAAAAAAA);
        vecs[3]  = mk(1,1,1,32'h55555555, 1,1,1,32'h12345678, 0,0,           0,32'hAAAAAAAA);
        vecs[4]  = mk(1,0,1,0,            1,0,1,0,           1,32'h55555555, 1,32'h55555555);
        vecs[5]  = mk(1,0,3,0,            1,1,7,32'h77,      1,32'hAAAAAAAA, 0,32'h55555555);
        vecs[6]  = mk(1,1,5,32'hCAFEF00D, 1,0,5,0,           0,32'hAAAAAAAA, 1,coll_b);
        vecs[7]  = mk(0,0,0,0,            1,0,5,0,           0,32'hAAAAAAAA, 1,32'hCAFEF00D);
        vecs[8]  = mk(1,0,9,0,            1,1,9,32'h99,      1,coll_a,       0,32'hCAFEF00D);
        vecs[9]  = mk(1,0,7,0,            1,0,9,0,           1,32'h77,       1,32'h99);
        vecs[10] = mk(1,0,15,0,           0,0,0,0,           1,0,            0,32'h99);
        vecs[11] = mk(0,1,4,32'hFFFF,     0,1,4,32'hEEEE,    0,0,            0,32'h99);
        vecs[12] = mk(1,0,4,0,            1,0,1,0,           1,0,            1,32'h55555555);

        idle_inputs();
        rst_n = 1'b0;

        // Reset with a preloaded word that the clear must remove.
        @(negedge clk);
        dut.r_mem[3] = 32'hDEADBEEF;
        step();
        step();
        check("reset_busy", DW'(busy), 1);
        check("reset_rdata_a", rdata_a, '0);
        check("reset_rdata_b", rdata_b, '0);
        check("reset_rvalid", DW'({rvalid_a, rvalid_b}), 0);
        rst_n = 1'b1;
        wait_idle("reset_clear");
        read_all_zero("after_reset");

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            en_a = vecs[i].en_a; we_a = vecs[i].we_a;
            addr_a = vecs[i].addr_a; wdata_a = vecs[i].wdata_a;
            en_b = vecs[i].en_b; we_b = vecs[i].we_b;
            addr_b = vecs[i].addr_b; wdata_b = vecs[i].wdata_b;
            step();
            idle_inputs();
            check($sformatf("vec%0d_rvalid_a", i), DW'(rvalid_a), DW'(vecs[i].exp_rvalid_a));
            check($sformatf("vec%0d_rdata_a", i), rdata_a, vecs[i].exp_rdata_a);
            check($sformatf("vec%0d_rvalid_b", i), DW'(rvalid_b), DW'(vecs[i].exp_rvalid_b));
            check($sformatf("vec%0d_rdata_b", i), rdata_b, vecs[i].exp_rdata_b);
        end

        // clr pulse, then a write and a read that must both be dropped.
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_busy_rise", DW'(busy), 1);
        en_a = 1'b1; we_a = 1'b1; addr_a = 4'd2; wdata_a = 32'h22222222;
        en_b = 1'b1; we_b = 1'b0; addr_b = 4'd2;
        begin
            int n = 1;
            int rv_seen = 0;
            while (busy === 1'b1 && n < BUSY_BOUND) begin
                step();
                idle_inputs();
                if (busy === 1'b1) n++;
                if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) rv_seen++;
            end
            check("clr_busy_cycles", DW'(n), DW'(DEPTH));
            check("clr_rvalid_quiet", DW'(rv_seen), 0);
        end
        check("clr_rdata_b_held", rdata_b, 32'h55555555);
        read_all_zero("after_clr");

        // Reset at clear cycle 7 restarts the full sequence.
        en_a = 1'b1; we_a = 1'b1; addr_a = 4'd12; wdata_a = 32'h0C0C0C0C;
        en_b = 1'b1; we_b = 1'b1; addr_b = 4'd3;  wdata_b = 32'h03030303;
        step();
        idle_inputs();
        en_a = 1'b1; we_a = 1'b0; addr_a = 4'd12;
        step();
        idle_inputs();
        check("pre_clear_rd12", rdata_a, 32'h0C0C0C0C);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("midclear_busy", DW'(busy), 1);
        rst_n = 1'b0;
        step();
        check("midreset_busy", DW'(busy), 1);
        check("midreset_rdata_a", rdata_a, '0);
        rst_n = 1'b1;
        wait_idle("restart_clear");
        read_all_zero("after_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
